bbox_raster_scanner: RTL and testbench
======================================

# bbox_raster_scanner

Parametrised pixel-sweep engine that replaces the free-running full-frame hcount/vcount sweep in front of `triangle_2d_fill` and the pixel BRAM write port. It accepts one job at a time, either a screen-space bounding box or a full-frame clear, and clips the box to the frame. It then emits LANES-wide pixel groups with frame coordinates, BRAM address and lane mask over a valid/ready stream, so only pixels that can be covered are visited.

## Interface
- FRAME_WIDTH, 512: frame width in pixels; multiple of LANES.
- FRAME_HEIGHT, 384: frame height in pixels.
- COORD_BITS, 16: width of signed job coordinates and unsigned output coordinates.
- ADDR_BITS, 18: pixel address width; must hold FRAME_WIDTH*FRAME_HEIGHT-1.
- LANES, 1: pixels per output beat; power of two, 1..8.
- COLOR_WIDTH, 16: padded color width.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  block can accept a job.
- job_clear  in  1  0 = bbox scan, 1 = full-frame clear (bbox ignored).
- job_xmin, job_xmax, job_ymin, job_ymax  in  COORD_BITS  signed two's-complement inclusive bounds.
- job_color  in  COLOR_WIDTH  color carried with every beat of the job.
- px_valid  out  1  beat valid.
- px_ready  in  1  downstream accepts beat.
- px_x  out  COORD_BITS  x of lane 0, always a multiple of LANES.
- px_y  out  COORD_BITS  row.
- px_addr  out  ADDR_BITS  px_y*FRAME_WIDTH + px_x.
- px_mask  out  LANES  bit i set when pixel px_x+i lies inside the clipped box.
- px_color  out  COLOR_WIDTH  registered job_color.
- px_clear  out  1  registered job_clear.
- px_last  out  1  final beat of the job.
- done  out  1  one-cycle pulse at job completion.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, SCAN, DONE.
- IDLE: job_ready=1. On job_valid&&job_ready, register the job and go to SETUP.
- SETUP: one cycle. Computes the clipped box.
  - cx0=max(xmin,0), cx1=min(xmax,FRAME_WIDTH-1), cy0=max(ymin,0), cy1=min(ymax,FRAME_HEIGHT-1); all compares are signed.
  - Clear mode forces the box to 0..FRAME_WIDTH-1 by 0..FRAME_HEIGHT-1.
  - Empty box (cx0>cx1 or cy0>cy1, including fully off-screen or inverted input): go to DONE with no beats.
  - Otherwise set x=cx0 rounded down to a multiple of LANES, y=cy0, and go to SCAN.
- SCAN: px_valid=1. On px_valid&&px_ready:
  - If x+LANES <= cx1, x += LANES.
  - Otherwise, at row end, x returns to the aligned cx0 and y += 1.
  - The beat with y==cy1 and x+LANES>cx1 carries px_last=1; its handshake moves the FSM to DONE.
- px_mask[i] = (cx0 <= x+i <= cx1). Clear beats always have all mask bits set.
- DONE: done=1 for exactly one cycle, then IDLE.
- job_valid outside IDLE is ignored (job_ready=0); there is no queueing.
- px_addr is maintained incrementally: +LANES per step, row base +FRAME_WIDTH per row. It must equal px_y*FRAME_WIDTH+px_x on every valid beat.

## Timing
- Reset (rst_n low, asynchronous): FSM to IDLE. job_ready=1; px_valid, px_last, done, busy=0; px_x, px_y, px_addr, px_mask, px_color, px_clear=0.
- Reset asserted mid-job aborts immediately: px_valid falls with no done pulse. The first job after release scans from its own start.
- Job accepted at edge T: SETUP during T+1; first px_valid at T+2.
- Throughput is one beat per cycle while px_ready is held high.
- While px_valid && !px_ready, all px_* outputs hold stable.
- Beat count = (cy1-cy0+1) * ((cx1_aligned - cx0_aligned)/LANES + 1).
- Last beat handshaked at edge N: done high in cycle N+1, job_ready high in cycle N+2.
- Empty job accepted at T: done high in cycle T+2, no px_valid.

## Test plan
- LANES=1, box (10,20)-(13,21), px_ready=1: 8 beats.
  - First beat x=10, y=20, addr=10250, at T+2.
  - Last beat x=13, y=21, addr=10765, px_last=1.
  - done one cycle later; job_ready the cycle after that.
- LANES=4, box x 5..10, y=0..0: exactly 2 beats.
  - Beat 1: x=4, mask 4'b1110.
  - Beat 2: x=8, mask 4'b0111, px_last=1.
- Clipping, LANES=1:
  - Box (-5,-3)-(2,1): 6 beats, first addr 0, last addr 514.
  - Box (600,0)-(700,10): zero beats, done at T+2.
  - Inverted box xmin>xmax: zero beats, done at T+2.
- Backpressure: px_ready pattern 1,0,0,1,... on the test-1 box.
  - Outputs stable during stalls.
  - Address sequence has no skipped or duplicated values.
  - job_valid pulses while busy are ignored.
- Clear mode, LANES=4, job_color=16'h0F0F: 49152 beats, all masks 4'b1111, px_clear=1, px_color=16'h0F0F, last addr 196604 with px_last=1.
- rst_n pulsed low during beat 3 of test 1:
  - px_valid, busy and done are low immediately.
  - job_ready=1 after release.
  - A new job restarts at its own first pixel.

Source files
------------

// File: rtl/bbox_raster_scanner_if.sv
// Job and pixel-stream bundle for bbox_raster_scanner.
// The master modport is the scanner side; slave is the job source / pixel sink.
interface bbox_raster_scanner_if #(
    parameter int COORD_BITS  = 16,
    parameter int ADDR_BITS   = 18,
    parameter int LANES       = 1,
    parameter int COLOR_WIDTH = 16
);
    logic                          job_valid;
    logic                          job_ready;
    logic                          job_clear;
    logic signed [COORD_BITS-1:0]  job_xmin;
    logic signed [COORD_BITS-1:0]  job_xmax;
    logic signed [COORD_BITS-1:0]  job_ymin;
    logic signed [COORD_BITS-1:0]  job_ymax;
    logic [COLOR_WIDTH-1:0]        job_color;

    logic                          px_valid;
    logic                          px_ready;
    logic [COORD_BITS-1:0]         px_x;
    logic [COORD_BITS-1:0]         px_y;
    logic [ADDR_BITS-1:0]          px_addr;
    logic [LANES-1:0]              px_mask;
    logic [COLOR_WIDTH-1:0]        px_color;
    logic                          px_clear;
    logic                          px_last;

    logic                          done;
    logic                          busy;

    modport master (
        input  job_valid, job_clear, job_xmin, job_xmax, job_ymin, job_ymax, job_color,
        input  px_ready,
        output job_ready,
        output px_valid, px_x, px_y, px_addr, px_mask, px_color, px_clear, px_last,
        output done, busy
    );

    modport slave (
        output job_valid, job_clear, job_xmin, job_xmax, job_ymin, job_ymax, job_color,
        output px_ready,
        input  job_ready,
        input  px_valid, px_x, px_y, px_addr, px_mask, px_color, px_clear, px_last,
        input  done, busy
    );
endinterface

// File: rtl/bbox_raster_scanner.sv
// Bounding-box pixel sweep: clips a job box to the frame and streams LANES-wide
// pixel groups with coordinates, BRAM address and lane mask.
module bbox_raster_scanner #(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 384,
    parameter int COORD_BITS   = 16,
    parameter int ADDR_BITS    = 18,
    parameter int LANES        = 1,
    parameter int COLOR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bbox_raster_scanner_if.master  bus
);

    localparam int CB = COORD_BITS;
    localparam logic signed [CB-1:0] XMAX_S     = CB'(FRAME_WIDTH - 1);
    localparam logic signed [CB-1:0] YMAX_S     = CB'(FRAME_HEIGHT - 1);
    localparam logic [CB:0]          LANES_W    = (CB+1)'(LANES);
    localparam logic [CB-1:0]        ALIGN_MASK = ~CB'(LANES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t                 state_q;
    logic                   job_clear_q;
    logic signed [CB-1:0]   job_xmin_q, job_xmax_q, job_ymin_q, job_ymax_q;
    logic [COLOR_WIDTH-1:0] job_color_q;

    logic [CB-1:0]          cx0_q, cx1_q, cy1_q, cx0a_q;
    logic [ADDR_BITS-1:0]   row_q;
    logic [CB-1:0]          x_q, y_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [LANES-1:0]       mask_q;
    logic                   valid_q, last_q, done_q, busy_q, ready_q;

    function automatic logic [LANES-1:0] mask_of(input logic [CB-1:0] x,
                                                 input logic [CB-1:0] lo,
                                                 input logic [CB-1:0] hi,
                                                 input logic          clr);
        logic [LANES-1:0] m;
        logic [CB:0]      xi;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            xi   = {1'b0, x} + (CB+1)'(i);
            m[i] = clr || ((xi >= {1'b0, lo}) && (xi <= {1'b0, hi}));
        end
        return m;
    endfunction

    function automatic logic last_of(input logic [CB-1:0] x, input logic [CB-1:0] y,
                                     input logic [CB-1:0] hi, input logic [CB-1:0] ylast);
        return (y == ylast) && (({1'b0, x} + LANES_W) > {1'b0, hi});
    endfunction

    // Clipped box from the registered job; signed compares catch off-screen and inverted input
    logic signed [CB-1:0]  clx0, clx1, cly0, cly1;
    logic                  box_empty;
    logic [CB-1:0]         clx0a;
    logic [ADDR_BITS-1:0]  start_addr;

    always_comb begin
        if (job_clear_q) begin
            clx0 = '0;
            clx1 = XMAX_S;
            cly0 = '0;
            cly1 = YMAX_S;
        end else begin
            clx0 = job_xmin_q[CB-1] ? '0 : job_xmin_q;
            clx1 = (job_xmax_q > XMAX_S) ? XMAX_S : job_xmax_q;
            cly0 = job_ymin_q[CB-1] ? '0 : job_ymin_q;
            cly1 = (job_ymax_q > YMAX_S) ? YMAX_S : job_ymax_q;
        end
        box_empty  = (clx0 > clx1) || (cly0 > cly1);
        clx0a      = $unsigned(clx0) & ALIGN_MASK;
        start_addr = ADDR_BITS'($unsigned(cly0)) * ADDR_BITS'(FRAME_WIDTH)
                   + ADDR_BITS'(clx0a);
    end

    // Next beat position; the address steps incrementally and the row base carries the wrap
    logic [CB:0]           step_x;
    logic                  row_end;
    logic [CB-1:0]         nx, ny;
    logic [ADDR_BITS-1:0]  naddr, nrow;
    logic [LANES-1:0]      nmask;
    logic                  nlast;

    always_comb begin
        step_x  = {1'b0, x_q} + LANES_W;
        row_end = step_x > {1'b0, cx1_q};
        if (row_end) begin
            nx    = cx0a_q;
            ny    = y_q + 1'b1;
            nrow  = row_q + ADDR_BITS'(FRAME_WIDTH);
            naddr = row_q + ADDR_BITS'(FRAME_WIDTH);
        end else begin
            nx    = step_x[CB-1:0];
            ny    = y_q;
            nrow  = row_q;
            naddr = addr_q + ADDR_BITS'(LANES);
        end
        nmask = mask_of(nx, cx0_q, cx1_q, job_clear_q);
        nlast = last_of(nx, ny, cx1_q, cy1_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_clear_q <= 1'b0;
            job_xmin_q  <= '0;
            job_xmax_q  <= '0;
            job_ymin_q  <= '0;
            job_ymax_q  <= '0;
            job_color_q <= '0;
            cx0_q       <= '0;
            cx1_q       <= '0;
            cy1_q       <= '0;
            cx0a_q      <= '0;
            row_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.job_valid) begin
                        job_clear_q <= bus.job_clear;
                        job_xmin_q  <= bus.job_xmin;
                        job_xmax_q  <= bus.job_xmax;
                        job_ymin_q  <= bus.job_ymin;
                        job_ymax_q  <= bus.job_ymax;
                        job_color_q <= bus.job_color;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    cx0_q  <= $unsigned(clx0);
                    cx1_q  <= $unsigned(clx1);
                    cy1_q  <= $unsigned(cly1);
                    cx0a_q <= clx0a;
                    if (box_empty) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q     <= clx0a;
                        y_q     <= $unsigned(cly0);
                        addr_q  <= start_addr;
                        row_q   <= start_addr;
                        mask_q  <= mask_of(clx0a, $unsigned(clx0), $unsigned(clx1), job_clear_q);
                        last_q  <= last_of(clx0a, $unsigned(cly0), $unsigned(clx1), $unsigned(cly1));
                        valid_q <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.px_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            x_q    <= nx;
                            y_q    <= ny;
                            addr_q <= naddr;
                            row_q  <= nrow;
                            mask_q <= nmask;
                            last_q <= nlast;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.job_ready = ready_q;
    assign bus.px_valid  = valid_q;
    assign bus.px_x      = x_q;
    assign bus.px_y      = y_q;
    assign bus.px_addr   = addr_q;
    assign bus.px_mask   = mask_q;
    assign bus.px_color  = job_color_q;
    assign bus.px_clear  = job_clear_q;
    assign bus.px_last   = last_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bbox_raster_scanner.sv
// Scoreboard bench for bbox_raster_scanner (LANES=4): a box-sweep reference model
// queues expected beats; a negedge monitor pops and compares.
module tb_bbox_raster_scanner;

    localparam int FW = 512;
    localparam int FH = 384;
    localparam int CB = 16;
    localparam int AB = 18;
    localparam int L  = 4;
    localparam int CW = 16;
    localparam int HW = 1 + CB + CB + AB + L + 1 + CW + 1;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int addr;
        int mask;
        int color;
        bit clr;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    bbox_raster_scanner_if #(.COORD_BITS(CB), .ADDR_BITS(AB), .LANES(L), .COLOR_WIDTH(CW)) bus ();

    bbox_raster_scanner #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COORD_BITS(CB),
        .ADDR_BITS(AB), .LANES(L), .COLOR_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: visit every aligned LANES group of the clipped box, row by row
    function automatic int model(input bit clr, input int x0, input int x1,
                                 input int y0, input int y1, input int color);
        int   cx0, cx1, cy0, cy1, n;
        exp_t e;
        n = 0;
        if (clr) begin
            cx0 = 0; cx1 = FW - 1; cy0 = 0; cy1 = FH - 1;
        end else begin
            cx0 = (x0 < 0) ? 0 : x0;
            cx1 = (x1 > FW - 1) ? FW - 1 : x1;
            cy0 = (y0 < 0) ? 0 : y0;
            cy1 = (y1 > FH - 1) ? FH - 1 : y1;
        end
        if (cx0 <= cx1 && cy0 <= cy1) begin
            for (int y = cy0; y <= cy1; y++) begin
                for (int x = (cx0 / L) * L; x <= cx1; x += L) begin
                    e.is_done = 1'b0;
                    e.x = x;
                    e.y = y;
                    e.addr = y * FW + x;
                    e.mask = 0;
                    for (int i = 0; i < L; i++)
                        if (x + i >= cx0 && x + i <= cx1) e.mask |= (1 << i);
                    e.color = color;
                    e.clr = clr;
                    e.last = (y == cy1) && (x + L > cx1);
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
        e = '{default: 0};
        e.is_done = 1'b1;
        exp_q.push_back(e);
        return n;
    endfunction

    initial begin
        bus.px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       bus.px_ready = 1'b1;
                1:       bus.px_ready = (cyc % 3 == 0);
                default: bus.px_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: beats and done pulses are popped in order; stalled outputs must hold
    initial begin
        logic [HW-1:0] hold_v;
        logic [HW-1:0] cur_v;
        bit            stall;
        exp_t          e;
        stall = 1'b0;
        hold_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                cur_v = {bus.px_valid, bus.px_x, bus.px_y, bus.px_addr, bus.px_mask,
                         bus.px_last, bus.px_color, bus.px_clear};
                if (stall) chk("stall_hold", cur_v, hold_v);
                if (bus.px_valid && bus.px_ready) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        chk("unexpected_beat", bus.px_addr, 0);
                        errors += (bus.px_addr == 0) ? 1 : 0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_x", bus.px_x, e.x);
                        chk("beat_y", bus.px_y, e.y);
                        chk("beat_addr", bus.px_addr, e.addr);
                        chk("beat_mask", bus.px_mask, e.mask);
                        chk("beat_last", bus.px_last, e.last);
                        chk("beat_color", bus.px_color, e.color);
                        chk("beat_clear", bus.px_clear, e.clr);
                    end
                end
                if (bus.done) begin
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e.is_done = 1'b0;
                    chk("done_order", e.is_done, 1);
                end
                stall  = bus.px_valid && !bus.px_ready;
                hold_v = cur_v;
            end
        end
    end

    task automatic start_job(input bit clr, input int x0, input int x1, input int y0,
                             input int y1, input int color, output int nb);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.job_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("job_ready_wait", bus.job_ready, 1);
        nb = model(clr, x0, x1, y0, y1, color);
        bus.job_valid = 1'b1;
        bus.job_clear = clr;
        bus.job_xmin  = CB'(x0);
        bus.job_xmax  = CB'(x1);
        bus.job_ymin  = CB'(y0);
        bus.job_ymax  = CB'(y1);
        bus.job_color = CW'(color);
        @(posedge clk);
        #1 bus.job_valid = 1'b0;
        @(negedge clk);
        chk("setup_cycle", {bus.busy, bus.px_valid, bus.done}, 3'b100);
        @(negedge clk);
        if (nb == 0) chk("empty_done_T2", {bus.px_valid, bus.done}, 2'b01);
        else         chk("first_beat_T2", {bus.px_valid, bus.done}, 2'b10);
    endtask

    task automatic finish_job(input int nb, input bit noise);
        int w, budget;
        w = 0;
        budget = nb * 6 + 40;
        while (!bus.done && w < budget) begin
            if (noise) begin
                bus.job_valid = 1'($urandom_range(0, 1));
                bus.job_clear = 1'($urandom_range(0, 1));
                bus.job_xmin  = CB'($urandom_range(0, 100));
                bus.job_xmax  = CB'($urandom_range(100, 300));
                bus.job_ymin  = CB'($urandom_range(0, 100));
                bus.job_ymax  = CB'($urandom_range(100, 300));
            end
            @(negedge clk);
            w++;
        end
        bus.job_valid = 1'b0;
        chk("done_seen", bus.done, 1);
        @(negedge clk);
        chk("ready_after_done", {bus.job_ready, bus.done, bus.busy}, 3'b100);
    endtask

    task automatic run_job(input bit clr, input int x0, input int x1, input int y0,
                           input int y1, input int color, input bit noise);
        int nb;
        start_job(clr, x0, x1, y0, y1, color, nb);
        finish_job(nb, noise);
    endtask

    initial begin
        int nb, x0, x1, y0, y1;
        bus.job_valid = 1'b0;
        bus.job_clear = 1'b0;
        bus.job_xmin = '0;
        bus.job_xmax = '0;
        bus.job_ymin = '0;
        bus.job_ymax = '0;
        bus.job_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {bus.job_ready, bus.px_valid, bus.px_last, bus.done, bus.busy}, 5'b10000);
        chk("rst_data", {bus.px_x, bus.px_y, bus.px_addr, bus.px_mask, bus.px_color, bus.px_clear}, 0);
        rst_n = 1'b1;

        ready_mode = 0;
        run_job(0, 10, 13, 20, 21, 16'h1234, 0);
        run_job(0, 5, 10, 0, 0, 16'h00AA, 0);
        run_job(0, -5, 2, -3, 1, 16'h5555, 0);
        run_job(0, 600, 700, 0, 10, 16'h0001, 0);
        run_job(0, 20, 10, 5, 6, 16'h0002, 0);
        run_job(0, 508, 530, 380, 400, 16'h0003, 0);

        ready_mode = 1;
        run_job(0, 10, 13, 20, 21, 16'hBEEF, 1);

        // Abort while the third beat is on the bus
        ready_mode = 0;
        start_job(0, 10, 13, 20, 21, 16'h7777, nb);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("abort_outputs", {bus.px_valid, bus.busy, bus.done, bus.job_ready}, 4'b0001);
        exp_q.delete();
        #20 rst_n = 1'b1;
        run_job(0, 100, 107, 50, 51, 16'h4242, 0);

        run_job(1, 0, 0, 0, 0, 16'h0F0F, 0);

        for (int j = 0; j < 40; j++) begin
            ready_mode = int'($urandom_range(0, 2));
            x0 = int'($urandom_range(0, 600)) - 40;
            x1 = x0 + int'($urandom_range(0, 44)) - 4;
            y0 = int'($urandom_range(0, 420)) - 20;
            y1 = y0 + int'($urandom_range(0, 10)) - 2;
            run_job(0, x0, x1, y0, y1, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
